// File: rtl/bh1750_i2c_target.sv
// BH1750 ambient-light sensor emulation as an I2C target on an open-drain bus.
// Define MEAS_DELAY_EN to model the measurement conversion time (MEAS_CYCLES).
module bh1750_i2c_target #(
   parameter logic [6:0]  I2C_ADDR    = 7'h23,
   parameter logic [23:0] MEAS_CYCLES = 24'd180000
) (
   input  logic        system_clock,
   input  logic        reset,
   input  logic        I2C_SCLK,
   inout  wire         I2C_SDA,
   input  logic [15:0] lux_value,
   output logic        powered_on,
   output logic [7:0]  meas_mode,
   output logic        cmd_valid,
   output logic        busy,
   output logic        sda_out_en_output,
   output logic [3:0]  presentState_output
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR     = 4'd1,
      ADDR_ACK = 4'd2,
      CMD      = 4'd3,
      CMD_ACK  = 4'd4,
      TX_BYTE  = 4'd5,
      TX_ACK   = 4'd6,
      IGNORE   = 4'd7
   } state_t;

   state_t      state, state_next;
   logic [2:0]  scl_sync, sda_sync;
   logic        scl, scl_prev, sda, sda_prev;
   logic        scl_rise, scl_fall, start_cond, stop_cond;
   logic [2:0]  bit_cnt, bit_cnt_next;
   logic [7:0]  shift, shift_next;
   logic        rw, rw_next;
   logic [6:0]  tx_shift, tx_shift_next;
   logic [1:0]  tx_idx, tx_idx_next;
   logic        acked, acked_next;
   logic        sda_en, sda_en_next;
   logic        busy_next;
   logic        cmd_strobe, reload_strobe;
   logic [15:0] data_reg;
   logic        continuous;
   logic [7:0]  tx_byte;

   assign I2C_SDA             = sda_en ? 1'b0 : 1'bz;
   assign sda_out_en_output   = sda_en;
   assign presentState_output = state;

   // Two synchronizer stages, third stage is history for edge detection.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[1:0], I2C_SCLK};
         sda_sync <= {sda_sync[1:0], I2C_SDA};
      end
   end

   assign scl        = scl_sync[1];
   assign scl_prev   = scl_sync[2];
   assign sda        = sda_sync[1];
   assign sda_prev   = sda_sync[2];
   assign scl_rise   = scl & ~scl_prev;
   assign scl_fall   = ~scl & scl_prev;
   assign start_cond = scl & scl_prev & sda_prev & ~sda;
   assign stop_cond  = scl & scl_prev & ~sda_prev & sda;

   always_comb begin
      case (tx_idx)
         2'd0:    tx_byte = data_reg[15:8];
         2'd1:    tx_byte = data_reg[7:0];
         default: tx_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge system_clock) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shift    <= '0;
         rw       <= 1'b0;
         tx_shift <= '1;
         tx_idx   <= '0;
         acked    <= 1'b0;
         sda_en   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         bit_cnt  <= bit_cnt_next;
         shift    <= shift_next;
         rw       <= rw_next;
         tx_shift <= tx_shift_next;
         tx_idx   <= tx_idx_next;
         acked    <= acked_next;
         sda_en   <= sda_en_next;
         busy     <= busy_next;
      end
   end

   always_comb begin
      state_next    = state;
      bit_cnt_next  = bit_cnt;
      shift_next    = shift;
      rw_next       = rw;
      tx_shift_next = tx_shift;
      tx_idx_next   = tx_idx;
      acked_next    = acked;
      sda_en_next   = sda_en;
      busy_next     = busy;
      cmd_strobe    = 1'b0;
      reload_strobe = 1'b0;
      if (stop_cond) begin
         state_next  = IDLE;
         sda_en_next = 1'b0;
         busy_next   = 1'b0;
      end else if (start_cond) begin
         state_next   = ADDR;
         bit_cnt_next = '0;
         sda_en_next  = 1'b0;
      end else begin
         case (state)
            ADDR, CMD: begin
               if (scl_rise) begin
                  shift_next   = {shift[6:0], sda};
                  bit_cnt_next = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == CMD) begin
                        state_next = CMD_ACK;
                     end else if (shift[6:0] == I2C_ADDR) begin
                        state_next = ADDR_ACK;
                        rw_next    = sda;
                        busy_next  = 1'b1;
                     end else begin
                        state_next = IGNORE;
                        busy_next  = 1'b0;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               // First fall starts the ACK, second fall ends it and hands SDA to the data phase.
               if (scl_fall) begin
                  if (!sda_en) begin
                     sda_en_next   = 1'b1;
                     reload_strobe = rw;
                  end else if (rw) begin
                     state_next    = TX_BYTE;
                     bit_cnt_next  = '0;
                     tx_idx_next   = '0;
                     tx_shift_next = data_reg[14:8];
                     sda_en_next   = ~data_reg[15];
                  end else begin
                     state_next   = CMD;
                     bit_cnt_next = '0;
                     sda_en_next  = 1'b0;
                  end
               end
            end
            CMD_ACK: begin
               if (scl_fall) begin
                  if (!sda_en) begin
                     sda_en_next = 1'b1;
                     cmd_strobe  = 1'b1;
                  end else begin
                     state_next   = CMD;
                     bit_cnt_next = '0;
                     sda_en_next  = 1'b0;
                  end
               end
            end
            TX_BYTE: begin
               if (scl_fall) begin
                  bit_cnt_next = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state_next  = TX_ACK;
                     sda_en_next = 1'b0;
                     acked_next  = 1'b0;
                  end else begin
                     sda_en_next   = ~tx_shift[6];
                     tx_shift_next = {tx_shift[5:0], 1'b1};
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  if (sda) begin
                     state_next = IGNORE;
                     busy_next  = 1'b0;
                  end else begin
                     acked_next = 1'b1;
                     if (tx_idx != 2'd3) tx_idx_next = tx_idx + 2'd1;
                  end
               end else if (scl_fall && acked) begin
                  state_next    = TX_BYTE;
                  bit_cnt_next  = '0;
                  tx_shift_next = tx_byte[6:0];
                  sda_en_next   = ~tx_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MEAS_DELAY_EN
   logic [23:0] meas_cnt;
   logic        ready;
`else
   if (MEAS_CYCLES == 24'd0) begin : g_immediate_latch
   end
`endif

   always_ff @(posedge system_clock) begin
      if (reset) begin
         powered_on <= 1'b0;
         meas_mode  <= '0;
         data_reg   <= '0;
         continuous <= 1'b0;
         cmd_valid  <= 1'b0;
`ifdef MEAS_DELAY_EN
         meas_cnt   <= '0;
         ready      <= 1'b1;
`endif
      end else begin
         cmd_valid <= cmd_strobe;
         if (cmd_strobe) begin
            case (shift)
               8'h00: powered_on <= 1'b0;
               8'h01: powered_on <= 1'b1;
               8'h07: if (powered_on) data_reg <= '0;
               8'h10, 8'h11, 8'h13, 8'h20, 8'h21, 8'h23: begin
                  meas_mode  <= shift;
                  continuous <= ~shift[5];
`ifdef MEAS_DELAY_EN
                  powered_on <= 1'b1;
                  ready      <= 1'b0;
                  meas_cnt   <= MEAS_CYCLES;
`else
                  // One-time modes latch now, so they power down immediately.
                  data_reg   <= lux_value;
                  powered_on <= ~shift[5];
`endif
               end
               default: ;
            endcase
         end
`ifdef MEAS_DELAY_EN
         else if (!ready) begin
            if (meas_cnt <= 24'd1) begin
               ready    <= 1'b1;
               data_reg <= lux_value;
               if (!continuous) powered_on <= 1'b0;
            end else begin
               meas_cnt <= meas_cnt - 24'd1;
            end
         end
`endif
         else if (reload_strobe && continuous && powered_on) begin
            data_reg <= lux_value;
         end
      end
   end

endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Scoreboard bench for bh1750_i2c_target: a bit-banged master pushes expected
// ACK/data/command results, monitors pop and compare as the DUT produces them.
module tb_bh1750_i2c_target;

   localparam int Q = 100;
   localparam logic [23:0] MEAS = 24'd2000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scl = 1'b1;
   logic        sda_low = 1'b0;
   logic [15:0] lux = 16'h0000;
   wire         sda_bus;
   logic        powered_on;
   logic [7:0]  meas_mode;
   logic        cmd_valid;
   logic        busy;
   logic        sda_en;
   logic [3:0]  st;

   int checks = 0;
   int passes = 0;

   string      exp_name_q[$];
   logic [7:0] exp_val_q[$];
   logic [7:0] obs_q[$];
   logic [8:0] exp_cmd_q[$];

   always #5 clk = ~clk;

   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   bh1750_i2c_target #(
      .I2C_ADDR   (7'h23),
      .MEAS_CYCLES(MEAS)
   ) dut (
      .system_clock       (clk),
      .reset              (reset),
      .I2C_SCLK           (scl),
      .I2C_SDA            (sda_bus),
      .lux_value          (lux),
      .powered_on         (powered_on),
      .meas_mode          (meas_mode),
      .cmd_valid          (cmd_valid),
      .busy               (busy),
      .sda_out_en_output  (sda_en),
      .presentState_output(st)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic i2c_start();
      sda_low = 1'b0;
      #Q scl = 1'b1;
      #Q sda_low = 1'b1;
      #Q scl = 1'b0;
      #Q;
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1;
      #Q scl = 1'b1;
      #Q sda_low = 1'b0;
      #(2*Q);
   endtask

   task automatic write_bit(input logic b);
      sda_low = ~b;
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
      #Q;
   endtask

   task automatic read_bit(output logic b);
      sda_low = 1'b0;
      #Q scl = 1'b1;
      #Q b = sda_bus;
      #Q scl = 1'b0;
      #Q;
   endtask

   task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack);
      logic a;
      exp_name_q.push_back(name);
      exp_val_q.push_back({7'b0, exp_ack});
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(a);
      obs_q.push_back({7'b0, a});
   endtask

   task automatic recv_byte(input string name, input logic [7:0] exp, input logic ack);
      logic [7:0] d;
      logic       b;
      exp_name_q.push_back(name);
      exp_val_q.push_back(exp);
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(~ack);
      obs_q.push_back(d);
   endtask

   task automatic write_cmd(input string name, input logic [7:0] op, input logic [8:0] exp_cmd);
      exp_cmd_q.push_back(exp_cmd);
      send_byte(name, op, 1'b0);
   endtask

   // Bus monitor: pairs each observed ACK bit / read byte with its expectation.
   initial begin : bus_mon
      logic [7:0] act;
      forever begin
         @(negedge clk);
         while (obs_q.size() != 0) begin
            act = obs_q.pop_front();
            if (exp_val_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_bus: got %h expected nothing", act);
            end else begin
               check(exp_name_q.pop_front(), {8'h00, act}, {8'h00, exp_val_q.pop_front()});
            end
         end
      end
   end

   // Command monitor: every cmd_valid pulse must match a queued {meas_mode, powered_on}.
   initial begin : cmd_mon
      forever begin
         @(negedge clk);
         if (cmd_valid === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_cmd_valid: got mode %h expected no pulse", meas_mode);
            end else begin
               check("cmd_valid", {7'b0, meas_mode, powered_on}, {7'b0, exp_cmd_q.pop_front()});
            end
         end
      end
   end

   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("reset_state", {12'h0, st}, 16'h0000);
      check("reset_outputs", {5'b0, sda_en, busy, cmd_valid, meas_mode}, 16'h0000);
      check("reset_powered", {15'b0, powered_on}, 16'h0000);

      // Write: address 0x23/W, continuous high-res opcode.
      lux = 16'h1234;
      i2c_start();
      send_byte("wr_addr_ack", 8'h46, 1'b0);
      check("wr_busy", {15'b0, busy}, 16'h0001);
      write_cmd("wr_cmd_ack", 8'h10, {8'h10, 1'b1});
      i2c_stop();
      check("wr_mode", {8'h0, meas_mode}, 16'h0010);
      check("wr_idle", {11'b0, busy, st}, 16'h0000);

`ifdef MEAS_DELAY_EN
      // Before the conversion completes the old (reset) value is returned.
      i2c_start();
      send_byte("dly_addr_ack", 8'h47, 1'b0);
      recv_byte("dly_early_hi", 8'h00, 1'b1);
      recv_byte("dly_early_lo", 8'h00, 1'b0);
      i2c_stop();
      repeat (int'(MEAS) + 50) @(posedge clk);
      i2c_start();
      send_byte("dly_addr_ack2", 8'h47, 1'b0);
      recv_byte("dly_late_hi", 8'h12, 1'b1);
      recv_byte("dly_late_lo", 8'h34, 1'b0);
      i2c_stop();
`endif

      // Continuous-mode read: reload at address ACK, ACK then NACK.
      lux = 16'hBEEF;
      i2c_start();
      send_byte("rd_addr_ack", 8'h47, 1'b0);
      recv_byte("rd_hi", 8'hBE, 1'b1);
      recv_byte("rd_lo", 8'hEF, 1'b0);
      #1;
      check("rd_nack_release", {11'b0, sda_en, st}, 16'h0007);
      i2c_stop();
      check("rd_stop", {11'b0, busy, st}, 16'h0000);

      // Foreign address: no ACK, no command decode.
      i2c_start();
      send_byte("foreign_nack", 8'hB8, 1'b1);
      check("foreign_state", {12'h0, st}, 16'h0007);
      send_byte("foreign_byte", 8'h10, 1'b1);
      i2c_stop();
      check("foreign_mode", {7'b0, meas_mode, powered_on}, {7'b0, 8'h10, 1'b1});

`ifndef MEAS_DELAY_EN
      // One-time mode: value held, device powers down after the latch.
      lux = 16'h00AA;
      i2c_start();
      send_byte("ot_addr_ack", 8'h46, 1'b0);
      write_cmd("ot_cmd_ack", 8'h20, {8'h20, 1'b0});
      i2c_stop();
      lux = 16'h5555;
      i2c_start();
      send_byte("ot_rd_addr", 8'h47, 1'b0);
      recv_byte("ot_hi", 8'h00, 1'b1);
      recv_byte("ot_lo", 8'hAA, 1'b0);
      i2c_stop();
      check("ot_powered", {15'b0, powered_on}, 16'h0000);

      // Reset opcode ignored while powered down, honoured after power-on.
      i2c_start();
      send_byte("rst_off_addr", 8'h46, 1'b0);
      write_cmd("rst_off_cmd", 8'h07, {8'h20, 1'b0});
      i2c_stop();
      i2c_start();
      send_byte("rst_off_rd", 8'h47, 1'b0);
      recv_byte("rst_off_hi", 8'h00, 1'b1);
      recv_byte("rst_off_lo", 8'hAA, 1'b0);
      i2c_stop();
      i2c_start();
      send_byte("rst_on_addr", 8'h46, 1'b0);
      write_cmd("pwr_on_cmd", 8'h01, {8'h20, 1'b1});
      write_cmd("rst_on_cmd", 8'h07, {8'h20, 1'b1});
      i2c_stop();
      i2c_start();
      send_byte("rst_on_rd", 8'h47, 1'b0);
      recv_byte("rst_on_hi", 8'h00, 1'b1);
      recv_byte("rst_on_lo", 8'h00, 1'b1);
      recv_byte("rd_past_end", 8'hFF, 1'b0);
      i2c_stop();
`endif

      // Repeated START in the middle of a read.
      lux = 16'h3C81;
      i2c_start();
      send_byte("rs_wr_addr", 8'h46, 1'b0);
      write_cmd("rs_cmd", 8'h11, {8'h11, 1'b1});
      i2c_stop();
`ifdef MEAS_DELAY_EN
      repeat (int'(MEAS) + 50) @(posedge clk);
`endif
      i2c_start();
      send_byte("rs_rd_addr", 8'h47, 1'b0);
      recv_byte("rs_hi_first", 8'h3C, 1'b1);
      i2c_start();
      check("rs_state_addr", {12'h0, st}, 16'h0001);
      send_byte("rs_rd_addr2", 8'h47, 1'b0);
      recv_byte("rs_hi", 8'h3C, 1'b1);
      recv_byte("rs_lo", 8'h81, 1'b0);
      i2c_stop();
      check("rs_idle", {12'h0, st}, 16'h0000);

      // Reset while the target is pulling SDA for the address ACK.
      i2c_start();
      exp_cmd_q.push_back(9'h0);
      void'(exp_cmd_q.pop_back());
      for (int i = 7; i >= 0; i--) write_bit(((8'h46 >> i) & 8'h01) != 8'h00);
      sda_low = 1'b0;
      #1;
      check("ack_drive", {11'b0, sda_en, st}, 16'h0012);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", {10'b0, sda_bus, sda_en, st}, 16'h0020);
      check("reset_busy", {15'b0, busy}, 16'h0000);
      @(negedge clk) reset = 1'b0;
      scl = 1'b1;
      #Q;
      i2c_stop();

      repeat (20) @(posedge clk);
      check("bus_queue_drained", 16'(exp_val_q.size()), 16'h0000);
      check("cmd_queue_drained", 16'(exp_cmd_q.size()), 16'h0000);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
